datapath: RTL and testbench
===========================

# datapath

Multicycle 32-bit ARM-subset datapath, directly downstream of the controller. It consumes every control strobe and select the controller produces and returns the fetched instruction and live ALU flags. It holds the architectural state: PC, R0–R14, and the non-architectural IR, Data, A, WriteData and ALUOut registers. It connects to a single unified instruction/data memory through an address, write-data and read-data port.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state while low.
- `PCWrite`, `IRWrite`, `RegWrite` input 1 each: load enables for PC, IR and the register file.
- `AdrSrc` input 1: memory address select.
- `RegSrc` input 2: register-file read-address selects.
- `ALUSrcA`, `ALUSrcB` input 2 each: ALU operand selects.
- `ResultSrc` input 2: result bus select.
- `ImmSrc` input 2: immediate format.
- `ALUControl` input 2: ALU operation.
- `ReadData` input 32: memory read data, valid in the same cycle as `Adr`.
- `Adr` output 32: memory address.
- `WriteData` output 32: registered store data. Memory write strobe comes from the controller.
- `Instr` output 32: IR contents. The controller uses [31:12].
- `ALUFlags` output 4: {N,Z,C,V} of the current ALU result, combinational.

## Operation
- `Adr` = `AdrSrc` ? Result : PC.
- Register loads:
  - IR loads `ReadData` when `IRWrite`=1.
  - Data loads `ReadData` every cycle.
  - PC loads Result when `PCWrite`=1.
- Register-file reads:
  - RA1 = `RegSrc[0]` ? 15 : Instr[19:16].
  - RA2 = `RegSrc[1]` ? Instr[15:12] : Instr[3:0].
  - Reading address 15 returns the Result bus (PC+8 during decode), not a stored register.
- Register-file write: when `RegWrite`=1, write address Instr[15:12] with Result. A write to address 15 is discarded; branches update PC only.
- A loads RD1 and WriteData loads RD2 every cycle. ALUOut loads ALUResult every cycle.
- Immediate extension by `ImmSrc`:
  - 00: zero-extend Instr[7:0].
  - 01: zero-extend Instr[11:0].
  - 10: sign-extend Instr[23:0], shifted left 2.
  - 11: 32'h0.
- SrcA by `ALUSrcA`: 00 A; 01 PC; 10 and 11 ALUOut.
- SrcB by `ALUSrcB`: 00 WriteData; 01 ExtImm; 10 and 11 constant 4.
- ALU operations by `ALUControl`:
  - 00 ADD: SrcA+SrcB.
  - 01 SUB: SrcA+~SrcB+1.
  - 10 AND.
  - 11 ORR.
- ALU flags:
  - N = result[31]; Z = (result==0).
  - For ADD/SUB: C = carry out of the 33-bit sum (for SUB, C=1 means no borrow). V = operands of equal sign (after SrcB inversion for SUB) and result sign differs.
  - For AND/ORR: C=0, V=0.
- Result by `ResultSrc`: 00 ALUOut; 01 Data; 10 and 11 ALUResult.

## Timing
- Reset (`reset` low, asynchronous):
  - PC=`RESET_PC`.
  - IR, Data, A, WriteData, ALUOut and R0–R14 = 0.
  - Consequently `Instr`=0, `WriteData`=0, `Adr`=`RESET_PC` when `AdrSrc`=0.
  - Reset dominates all enables and may assert in any cycle; it aborts the current instruction.
- Combinational paths, same cycle: `Adr`, `ALUFlags`, Result, and register-file reads. No combinational path from `ReadData` to any output except through Result when `AdrSrc`=1, which the controller never uses together with `ResultSrc`=01.
- Fetch-to-IR latency: one edge. Load data reaches Result one edge after `Adr` is presented, via Data.
- Register-file write takes effect at the edge. A same-cycle read of that address returns the old value, and A/WriteData capture the old value at that edge.
- PCWrite and RegWrite asserted together: both update from the same Result value at the same edge.
- PC+4 arithmetic wraps modulo 2^32. No overflow trap.

## Structure
- Shared package `arm_pkg`:
  - ALUControl codes ADD/SUB/AND/ORR.
  - Codes for ImmSrc, ResultSrc, ALUSrcA and ALUSrcB.
  - `REG_PC`=4'd15, `PC_STEP`=32'd4.
  - Flag bit indices N=3, Z=2, C=1, V=0.
- The controller imports the same package.
- One natural sub-module: `regfile`, which holds 15×32 storage, two async read ports, one sync write port, and the r15 bypass input. Extend, ALU and muxes stay inline.

## Test plan
- Reset: hold `reset`=0 with `RESET_PC`=0 and all enables at 1 for 3 cycles, then release -> `Adr`=0, `Instr`=0, `WriteData`=0, and R0–R14 all read 0.
- Fetch:
  - Stimulus: `ReadData`=32'hE281_1005, `AdrSrc`=0, `IRWrite`=1, `ALUSrcA`=01, `ALUSrcB`=10, `ALUControl`=00, `ResultSrc`=10, `PCWrite`=1.
  - Response after one edge: PC=4, `Adr`=4, `Instr`=32'hE281_1005.
- Flags:
  - A=32'h7FFF_FFFF plus imm 1 (ADD) -> result 32'h8000_0000, flags 4'b1001.
  - SUB 5-5 -> flags 4'b0110.
  - AND of 32'hF0 and 32'h0F -> flags 4'b0100.
- Register write/read:
  - RegWrite Result=32'h1234 to R3, then read RA2=3 -> 32'h1234.
  - Write to R15 -> PC and R15 reads unchanged.
  - RA1=15 with ResultSrc=10 -> read returns ALUResult.
- Load path: `Adr`=32'h40, `ReadData`=32'hDEAD_BEEF -> next cycle `ResultSrc`=01 gives Result=32'hDEAD_BEEF; RegWrite to R7 -> R7=32'hDEAD_BEEF.
- Reset mid-op: assert `reset`=0 between edges while PCWrite=1 -> PC returns to `RESET_PC` immediately (asynchronously) and IR=0; the first edge after release resumes fetch from `RESET_PC`.

Source files
------------

// File: rtl/arm_pkg.sv
// Encodings shared by the ARM-subset controller and datapath.
// Covers select codes, ALU ops, flag bit positions, PC constants and the immediate extender.
package arm_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_8    = 2'b00,
    IMM_12   = 2'b01,
    IMM_BR   = 2'b10,
    IMM_ZERO = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALUOUT  = 2'b00,
    RES_DATA    = 2'b01,
    RES_ALU     = 2'b10,
    RES_ALU_ALT = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    SRCA_A          = 2'b00,
    SRCA_PC         = 2'b01,
    SRCA_ALUOUT     = 2'b10,
    SRCA_ALUOUT_ALT = 2'b11
  } srca_e;

  typedef enum logic [1:0] {
    SRCB_WD       = 2'b00,
    SRCB_IMM      = 2'b01,
    SRCB_FOUR     = 2'b10,
    SRCB_FOUR_ALT = 2'b11
  } srcb_e;

  localparam logic [3:0]  REG_PC  = 4'd15;
  localparam logic [31:0] PC_STEP = 32'd4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [31:0] extend(input logic [23:0] imm, input imm_src_e src);
    logic [31:0] ext;
    ext = 32'h0;
    case (src)
      IMM_8:   ext = {24'h0, imm[7:0]};
      IMM_12:  ext = {20'h0, imm[11:0]};
      IMM_BR:  ext = {{6{imm[23]}}, imm, 2'b00};
      default: ext = 32'h0;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/datapath_if.sv
// Controller/memory-facing bundle of the multicycle datapath.
// Master drives strobes, selects and read data; slave returns address, store data, IR and flags.
interface datapath_if;
  import arm_pkg::*;

  logic        PCWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  srca_e       ALUSrcA;
  srcb_e       ALUSrcB;
  result_src_e ResultSrc;
  imm_src_e    ImmSrc;
  alu_op_e     ALUControl;
  logic [31:0] ReadData;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;

  modport master (
    output PCWrite, IRWrite, RegWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, ALUControl, ReadData,
    input  Adr, WriteData, Instr, ALUFlags
  );

  modport slave (
    input  PCWrite, IRWrite, RegWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, ALUControl, ReadData,
    output Adr, WriteData, Instr, ALUFlags
  );

endinterface

// File: rtl/datapath_regfile.sv
// R0-R14 storage with two async read ports; address 15 reads the r15 bypass input.
// Writes land at the clock edge; writes to 15 are dropped; no backpressure.
module regfile
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [3:0]  wa,
  input  logic [31:0] wd,
  input  logic [3:0]  ra1,
  input  logic [3:0]  ra2,
  input  logic [31:0] r15,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] mem [0:14];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 15; i++) mem[i] <= '0;
    end else if (we && (wa != REG_PC)) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == REG_PC) ? r15 : mem[ra1];
  assign rd2 = (ra2 == REG_PC) ? r15 : mem[ra2];

endmodule

// File: rtl/datapath.sv
// Multicycle ARM-subset datapath: PC, IR, Data, A, WriteData, ALUOut, register file, extender, ALU.
// Adr/ALUFlags/Result are same-cycle combinational; registers update on the edge; no backpressure.
module datapath
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic       clk,
  input logic       reset,
  datapath_if.slave dp
);

  logic [31:0] pc, ir, data, a, wdata, aluout;
  logic [31:0] rd1, rd2, ext_imm, src_a, src_b, src_b_eff, alu_result, result;
  logic [32:0] sum;
  logic [3:0]  ra1, ra2, flags;
  logic        is_sub, is_arith;

  assign ra1 = dp.RegSrc[0] ? REG_PC : ir[19:16];
  assign ra2 = dp.RegSrc[1] ? ir[15:12] : ir[3:0];

  regfile u_regfile (
    .clk (clk),
    .reset (reset),
    .we  (dp.RegWrite),
    .wa  (ir[15:12]),
    .wd  (result),
    .ra1 (ra1),
    .ra2 (ra2),
    .r15 (result),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      data   <= '0;
      a      <= '0;
      wdata  <= '0;
      aluout <= '0;
    end else begin
      if (dp.PCWrite) pc <= result;
      if (dp.IRWrite) ir <= dp.ReadData;
      data   <= dp.ReadData;
      a      <= rd1;
      wdata  <= rd2;
      aluout <= alu_result;
    end
  end

  always_comb begin
    ext_imm    = extend(ir[23:0], dp.ImmSrc);
    src_a      = aluout;
    src_b      = PC_STEP;
    alu_result = '0;
    result     = '0;
    flags      = '0;

    case (dp.ALUSrcA)
      SRCA_A:  src_a = a;
      SRCA_PC: src_a = pc;
      default: src_a = aluout;
    endcase

    case (dp.ALUSrcB)
      SRCB_WD:  src_b = wdata;
      SRCB_IMM: src_b = ext_imm;
      default:  src_b = PC_STEP;
    endcase

    // SUB is ADD of the inverted operand with carry-in, so C means "no borrow".
    is_sub    = (dp.ALUControl == ALU_SUB);
    is_arith  = (dp.ALUControl == ALU_ADD) || is_sub;
    src_b_eff = is_sub ? ~src_b : src_b;
    sum       = {1'b0, src_a} + {1'b0, src_b_eff} + {32'd0, is_sub};

    case (dp.ALUControl)
      ALU_AND: alu_result = src_a & src_b;
      ALU_ORR: alu_result = src_a | src_b;
      default: alu_result = sum[31:0];
    endcase

    flags[FLAG_N] = alu_result[31];
    flags[FLAG_Z] = (alu_result == 32'h0);
    flags[FLAG_C] = is_arith & sum[32];
    flags[FLAG_V] = is_arith & (src_a[31] == src_b_eff[31]) & (alu_result[31] != src_a[31]);

    case (dp.ResultSrc)
      RES_ALUOUT: result = aluout;
      RES_DATA:   result = data;
      default:    result = alu_result;
    endcase
  end

  assign dp.Adr       = dp.AdrSrc ? result : pc;
  assign dp.WriteData = wdata;
  assign dp.Instr     = ir;
  assign dp.ALUFlags  = flags;

endmodule

// File: tb/tb_datapath.sv
// Directed-vector bench for the multicycle datapath; all state is observed through Adr/Instr/WriteData/ALUFlags.
// Inputs change on the falling edge; outputs are sampled on or just after the falling edge.
module tb_datapath;
  import arm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  datapath_if dif ();

  datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    dif.PCWrite    = 1'b0;
    dif.IRWrite    = 1'b0;
    dif.RegWrite   = 1'b0;
    dif.AdrSrc     = 1'b0;
    dif.RegSrc     = 2'b00;
    dif.ALUSrcA    = SRCA_A;
    dif.ALUSrcB    = SRCB_WD;
    dif.ResultSrc  = RES_ALU;
    dif.ImmSrc     = IMM_8;
    dif.ALUControl = ALU_ADD;
    dif.ReadData   = 32'h0;
  endtask

  task automatic load_ir(input logic [31:0] w);
    dif.ReadData = w;
    dif.IRWrite  = 1'b1;
    step();
    dif.IRWrite  = 1'b0;
  endtask

  // Writes v into register Instr[15:12] through the Data path, then lets A/WriteData pick it up.
  task automatic load_reg(input logic [31:0] v);
    dif.ReadData  = v;
    step();
    dif.ResultSrc = RES_DATA;
    dif.RegWrite  = 1'b1;
    step();
    dif.RegWrite  = 1'b0;
    dif.ResultSrc = RES_ALU;
    step();
  endtask

  // R1 <- rv, then ALU(A=R1, imm8 of the IR); checks result (via Adr) and flags.
  task automatic flag_vec(input string tag, input logic [31:0] irw, input logic [31:0] rv,
                          input alu_op_e op, input logic [31:0] exp_res, input logic [3:0] exp_flags);
    idle();
    load_ir(irw);
    load_reg(rv);
    dif.ALUSrcA    = SRCA_A;
    dif.ALUSrcB    = SRCB_IMM;
    dif.ImmSrc     = IMM_8;
    dif.ALUControl = op;
    dif.ResultSrc  = RES_ALU;
    dif.AdrSrc     = 1'b1;
    #1;
    chk({tag, "_res"}, dif.Adr, exp_res);
    chk({tag, "_flags"}, {28'h0, dif.ALUFlags}, {28'h0, exp_flags});
    idle();
  endtask

  initial begin
    // Reset held with every enable high.
    reset          = 1'b0;
    idle();
    dif.PCWrite    = 1'b1;
    dif.IRWrite    = 1'b1;
    dif.RegWrite   = 1'b1;
    dif.ALUSrcA    = SRCA_PC;
    dif.ALUSrcB    = SRCB_FOUR;
    dif.ReadData   = 32'hFFFF_FFFF;
    repeat (3) step();
    idle();
    reset = 1'b1;
    #1;
    chk("rst_adr", dif.Adr, 32'h0);
    chk("rst_instr", dif.Instr, 32'h0);
    chk("rst_wdata", dif.WriteData, 32'h0);
    for (int i = 0; i < 15; i++) begin
      load_ir(32'(i));
      step();
      chk($sformatf("rst_r%0d", i), dif.WriteData, 32'h0);
    end

    // Fetch: PC+4 and IR load on one edge.
    dif.ReadData   = 32'hE281_1005;
    dif.IRWrite    = 1'b1;
    dif.PCWrite    = 1'b1;
    dif.ALUSrcA    = SRCA_PC;
    dif.ALUSrcB    = SRCB_FOUR;
    dif.ResultSrc  = RES_ALU;
    #1;
    chk("fetch_adr_pre", dif.Adr, 32'h0);
    step();
    chk("fetch_adr", dif.Adr, 32'h4);
    chk("fetch_instr", dif.Instr, 32'hE281_1005);
    idle();

    // ALU and flags.
    flag_vec("add_ovf",    32'hE281_1001, 32'h7FFF_FFFF, ALU_ADD, 32'h8000_0000, 4'b1001);
    flag_vec("sub_eq",     32'hE281_1005, 32'h0000_0005, ALU_SUB, 32'h0000_0000, 4'b0110);
    flag_vec("and_zero",   32'hE281_100F, 32'h0000_00F0, ALU_AND, 32'h0000_0000, 4'b0100);
    flag_vec("add_carry",  32'hE281_1001, 32'hFFFF_FFFF, ALU_ADD, 32'h0000_0000, 4'b0110);
    flag_vec("sub_borrow", 32'hE281_1005, 32'h0000_0003, ALU_SUB, 32'hFFFF_FFFE, 4'b1000);
    flag_vec("sub_ovf",    32'hE281_1001, 32'h8000_0000, ALU_SUB, 32'h7FFF_FFFF, 4'b0011);
    flag_vec("orr",        32'hE281_10F0, 32'h0000_000F, ALU_ORR, 32'h0000_00FF, 4'b0000);

    // R3 write: same-edge capture sees the old value, next edge the new one.
    load_ir(32'hE281_3005);
    dif.ReadData  = 32'h0000_1234;
    step();
    dif.ResultSrc = RES_DATA;
    dif.RegWrite  = 1'b1;
    dif.RegSrc    = 2'b10;
    step();
    chk("r3_old", dif.WriteData, 32'h0);
    dif.RegWrite  = 1'b0;
    step();
    chk("r3_new", dif.WriteData, 32'h0000_1234);
    idle();

    // Write to R15 is discarded; PC and R3 untouched.
    load_ir(32'hE281_F005);
    dif.ReadData  = 32'hCAFE_0000;
    step();
    dif.ResultSrc = RES_DATA;
    dif.RegWrite  = 1'b1;
    step();
    idle();
    #1;
    chk("r15_pc", dif.Adr, 32'h4);
    load_ir(32'hE281_F003);
    step();
    chk("r15_r3", dif.WriteData, 32'h0000_1234);

    // RA1=15 returns the Result bus (PC+4 = 8), captured in A.
    idle();
    dif.RegSrc     = 2'b01;
    dif.ALUSrcA    = SRCA_PC;
    dif.ALUSrcB    = SRCB_FOUR;
    step();
    dif.RegSrc     = 2'b00;
    dif.ALUSrcA    = SRCA_A;
    dif.ALUSrcB    = SRCB_IMM;
    dif.ImmSrc     = IMM_ZERO;
    dif.AdrSrc     = 1'b1;
    #1;
    chk("r15_bypass", dif.Adr, 32'h8);
    idle();

    // Immediate formats added to PC=4.
    load_ir(32'hE3A0_1FAB);
    dif.ALUSrcA = SRCA_PC;
    dif.ALUSrcB = SRCB_IMM;
    dif.AdrSrc  = 1'b1;
    dif.ImmSrc  = IMM_8;
    #1;
    chk("imm8", dif.Adr, 32'h0000_00AF);
    dif.ImmSrc  = IMM_12;
    #1;
    chk("imm12", dif.Adr, 32'h0000_0FAF);
    idle();
    load_ir(32'hEAFF_FFFE);
    dif.ALUSrcA = SRCA_PC;
    dif.ALUSrcB = SRCB_IMM;
    dif.ImmSrc  = IMM_BR;
    dif.AdrSrc  = 1'b1;
    #1;
    chk("imm_br", dif.Adr, 32'hFFFF_FFFC);
    chk("imm_br_flags", {28'h0, dif.ALUFlags}, 32'h8);
    idle();

    // Load path: Adr=0x40, data returns through Data, written to R7.
    load_ir(32'hE597_703C);
    dif.ALUSrcA    = SRCA_PC;
    dif.ALUSrcB    = SRCB_IMM;
    dif.ImmSrc     = IMM_12;
    dif.AdrSrc     = 1'b1;
    dif.ReadData   = 32'hDEAD_BEEF;
    #1;
    chk("ld_adr", dif.Adr, 32'h0000_0040);
    step();
    dif.ReadData   = 32'h0;
    dif.ResultSrc  = RES_DATA;
    dif.RegWrite   = 1'b1;
    #1;
    chk("ld_result", dif.Adr, 32'hDEAD_BEEF);
    step();
    idle();
    dif.RegSrc     = 2'b10;
    step();
    chk("ld_r7", dif.WriteData, 32'hDEAD_BEEF);
    idle();

    // PCWrite and RegWrite together take the same Result.
    load_ir(32'hE281_3005);
    dif.ALUSrcA  = SRCA_PC;
    dif.ALUSrcB  = SRCB_FOUR;
    dif.PCWrite  = 1'b1;
    dif.RegWrite = 1'b1;
    step();
    idle();
    chk("dual_pc", dif.Adr, 32'h8);
    dif.RegSrc   = 2'b10;
    step();
    chk("dual_r3", dif.WriteData, 32'h8);
    idle();

    // PC+4 wraps past 2^32.
    dif.ReadData  = 32'hFFFF_FFFC;
    step();
    dif.ResultSrc = RES_DATA;
    dif.PCWrite   = 1'b1;
    step();
    idle();
    #1;
    chk("wrap_pc", dif.Adr, 32'hFFFF_FFFC);
    dif.ALUSrcA   = SRCA_PC;
    dif.ALUSrcB   = SRCB_FOUR;
    dif.PCWrite   = 1'b1;
    #1;
    chk("wrap_flags", {28'h0, dif.ALUFlags}, 32'h6);
    step();
    idle();
    chk("wrap_adr", dif.Adr, 32'h0);

    // Reset mid-fetch: asynchronous clear, then fetch resumes from RESET_PC.
    dif.ReadData = 32'hE281_1005;
    dif.IRWrite  = 1'b1;
    dif.PCWrite  = 1'b1;
    dif.ALUSrcA  = SRCA_PC;
    dif.ALUSrcB  = SRCB_FOUR;
    step();
    chk("mid_pre", dif.Adr, 32'h4);
    #2 reset = 1'b0;
    #1;
    chk("mid_adr", dif.Adr, 32'h0);
    chk("mid_instr", dif.Instr, 32'h0);
    step();
    chk("mid_hold", dif.Adr, 32'h0);
    reset        = 1'b1;
    dif.ReadData = 32'hE3A0_1001;
    step();
    chk("resume_adr", dif.Adr, 32'h4);
    chk("resume_instr", dif.Instr, 32'hE3A0_1001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
